// File: rtl/ll_pkg.sv
// Shared helpers for the line-length feature units: output width sizing and
// the absolute sample difference.
package ll_pkg;

  localparam int MAX_DW = 64;

  function automatic int clog2(input int value);
    return $clog2(value);
  endfunction

  function automatic int sum_w(input int data_width, input int win_len);
    return data_width + clog2(win_len);
  endfunction

  // Operands are sign-extended samples of at most MAX_DW bits, so the
  // difference never overflows MAX_DW+1 bits.
  function automatic logic [MAX_DW:0] abs_diff(input logic signed [MAX_DW:0] a,
                                               input logic signed [MAX_DW:0] b);
    logic signed [MAX_DW:0] d;
    d = a - b;
    return d[MAX_DW] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/ll_window_unit_if.sv
// Sample/feature bus of the windowed line-length unit; the feeder drives master,
// the unit sits on slave.
interface ll_window_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SUM_W      = 36
);
  logic                         clr;
  logic                         en;
  logic signed [DATA_WIDTH-1:0] din;
  logic        [SUM_W-1:0]      thresh;
  logic        [SUM_W-1:0]      dout;
  logic                         data_valid;
  logic                         above_thresh;

  modport master (
    output clr, en, din, thresh,
    input  dout, data_valid, above_thresh
  );

  modport slave (
    input  clr, en, din, thresh,
    output dout, data_valid, above_thresh
  );
endinterface

// File: rtl/ll_diff_ring.sv
// Ring of the last WIN_LEN differences with write pointer and saturating fill count;
// the oldest entry is read combinationally at wr_ptr before it is overwritten.
module ll_diff_ring #(
  parameter int DATA_WIDTH = 32,
  parameter int WIN_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic [DATA_WIDTH-1:0] oldest,
  output logic                  full,
  output logic                  full_after
);
  localparam int PTR_W  = $clog2(WIN_LEN);
  localparam int FILL_W = $clog2(WIN_LEN + 1);

  logic [DATA_WIDTH-1:0] mem [WIN_LEN];
  logic [PTR_W-1:0]      wr_ptr;
  logic [FILL_W-1:0]     fill;

  // Contents are never cleared; the fill count decides whether they count.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr) begin
      wr_ptr <= (wr_ptr == PTR_W'(WIN_LEN - 1)) ? '0 : wr_ptr + 1'b1;
      if (!full) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign oldest     = mem[wr_ptr];
  assign full       = (fill == FILL_W'(WIN_LEN));
  assign full_after = (fill >= FILL_W'(WIN_LEN - 1));

endmodule

// File: rtl/ll_window_unit.sv
// Windowed line-length feature: sliding sum of |x[n]-x[n-1]| over WIN_LEN diffs, 2-edge
// latency, one sample per cycle, no backpressure; dout holds between data_valid pulses.
module ll_window_unit
  import ll_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIN_LEN    = 16,
  parameter int NORMALIZE  = 0,
  localparam int LOG_WIN   = clog2(WIN_LEN),
  localparam int SUM_W     = sum_w(DATA_WIDTH, WIN_LEN)
) (
  input logic              clk,
  input logic              rst,
  ll_window_unit_if.slave  bus
);
  logic signed [DATA_WIDTH-1:0] prev;
  logic                         primed;
  logic        [DATA_WIDTH-1:0] diff_r;
  logic                         diff_v;
  logic        [SUM_W-1:0]      sum;

  logic signed [MAX_DW:0]       din_ext;
  logic signed [MAX_DW:0]       prev_ext;
  logic        [MAX_DW:0]       diff_full;
  logic        [DATA_WIDTH-1:0] diff_w;

  logic                         clear;
  logic                         ring_wr;
  logic        [DATA_WIDTH-1:0] oldest;
  logic                         full;
  logic                         full_after;
  logic        [SUM_W-1:0]      sum_next;
  logic        [SUM_W-1:0]      dout_next;
  logic                         update_out;

  assign din_ext   = {{(MAX_DW + 1 - DATA_WIDTH){bus.din[DATA_WIDTH-1]}}, bus.din};
  assign prev_ext  = {{(MAX_DW + 1 - DATA_WIDTH){prev[DATA_WIDTH-1]}}, prev};
  assign diff_full = abs_diff(din_ext, prev_ext);
  assign diff_w    = diff_full[DATA_WIDTH-1:0];

  // Two signed DATA_WIDTH samples are never more than 2^DATA_WIDTH-1 apart.
  always_comb begin
    assert (diff_full[MAX_DW:DATA_WIDTH] == '0);
  end

  // Stage 1: prime/prev tracking and the registered difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed <= 1'b0;
      prev   <= '0;
      diff_v <= 1'b0;
      diff_r <= '0;
    end else if (bus.clr) begin
      primed <= bus.en;
      diff_v <= 1'b0;
      if (bus.en) begin
        prev <= bus.din;
      end
    end else begin
      diff_v <= bus.en && primed;
      if (bus.en) begin
        prev   <= bus.din;
        primed <= 1'b1;
        diff_r <= diff_w;
      end
    end
  end

  assign clear   = rst || bus.clr;
  assign ring_wr = diff_v && !clear;

  ll_diff_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIN_LEN    (WIN_LEN)
  ) u_ring (
    .clk        (clk),
    .clear      (clear),
    .wr         (ring_wr),
    .wr_dat     (diff_r),
    .oldest     (oldest),
    .full       (full),
    .full_after (full_after)
  );

  assign sum_next   = sum + {{LOG_WIN{1'b0}}, diff_r}
                          - (full ? {{LOG_WIN{1'b0}}, oldest} : '0);
  assign dout_next  = (NORMALIZE != 0) ? (sum_next >> LOG_WIN) : sum_next;
  assign update_out = diff_v && full_after;

  // Stage 2: accumulator, output register and threshold compare.
  always_ff @(posedge clk) begin
    if (clear) begin
      sum              <= '0;
      bus.dout         <= '0;
      bus.data_valid   <= 1'b0;
      bus.above_thresh <= 1'b0;
    end else begin
      bus.data_valid   <= update_out;
      bus.above_thresh <= update_out && (dout_next > bus.thresh);
      if (diff_v) begin
        sum <= sum_next;
      end
      if (update_out) begin
        bus.dout <= dout_next;
      end
    end
  end

endmodule
